riscv_data_mem_responder: RTL
=============================

// Module: riscv_data_mem_responder
// PURPOSE
//  Memory-side responder for the core's data memory interface; sits outside riscv_top on data_mem_*.
//  Word-organised RAM with byte/half/word lane steering, same-cycle reads and clock-edge writes.
//  Flags misaligned or out-of-range accesses in a sticky error register.
//  Provides saturating access counters and a post-reset init FSM.
// PARAMETERS
//  BASE_ADDR  32'h0000_2000  byte address of word 0
//  DEPTH      1024           number of 32-bit words (power of 2); AW = $clog2(DEPTH)
//  CNT_W      16             width of read/write access counters
// PORTS
//  clk                 in   1      clock
//  reset_n             in   1      asynchronous active-low reset
//  data_mem_req_i      in   1      access request, one access per cycle
//  data_mem_addr_i     in   32     byte address
//  data_mem_byte_en_i  in   2      size: 00 byte, 01 half, 10 word, 11 reserved
//  data_mem_wr_i       in   1      1 = store, 0 = load
//  data_mem_wr_data_i  in   32     store data, right-aligned (byte in [7:0], half in [15:0])
//  data_mem_rd_data_o  out  32     load data, right-aligned, upper bits zero
//  mem_ready_o         out  1      1 = accesses are serviced
//  mem_err_o           out  1      sticky error flag
//  err_addr_o          out  32     address of the first error since last clear
//  err_clr_i           in   1      synchronous clear of mem_err_o / err_addr_o
//  rd_cnt_o            out  CNT_W  serviced loads, saturating
//  wr_cnt_o            out  CNT_W  serviced stores, saturating
// BEHAVIOUR
//  - Clock and reset: single clk, reset_n asynchronous active-low. Reset sets every register output to 0.
//  - Reset values: mem_ready_o=0, mem_err_o=0, err_addr_o=0, rd_cnt_o=0, wr_cnt_o=0. RAM contents are not reset.
//  - FSM states: INIT, READY. Reset enters INIT. mem_ready_o=1 only in READY.
//  - Reset asserted mid-INIT or mid-operation returns to INIT with the clear index at 0.
//  - Decode: off = addr - BASE_ADDR; idx = off[AW+1:2]; lane = off[1:0].
//  - in_range = (addr >= BASE_ADDR) && (off < DEPTH*4).
//  - Alignment: half requires lane[0]=0; word requires lane=00; size 11 is always illegal.
//  - Valid access = req && ready && in_range && aligned && size!=11.
//  - Load (valid, wr=0): combinational, same cycle.
//    Byte -> {24'b0, word[8*lane +: 8]}; half -> {16'b0, word[8*lane +: 16]}; word -> full word.
//  - Load output is 0 when there is no valid load (idle, store, error, not ready).
//  - Store (valid, wr=1): lanes written at the posedge. Byte -> lane only; half -> lanes lane, lane+1; word -> all 4.
//  - A load of the same address in the next cycle returns the new data. No read-during-write forwarding is needed (single port).
//  - Error: req && ready && !valid sets mem_err_o at the next edge. err_addr_o captures the address only if mem_err_o was 0.
//  - An erroneous store writes nothing.
//  - err_clr_i has priority over a coincident new error: the flag ends cleared.
//  - req while not ready: ignored; no error, no count, no write.
//  - Counters: +1 per valid load / valid store at the posedge. They hold at 2^CNT_W-1 and never wrap.
//  - Widths: all offset arithmetic in 32 bits unsigned. BASE_ADDR + DEPTH*4 must not exceed 2^32.
// CONFIGURATION
//  DMEM_INIT_CLEAR_EN defined:
//    INIT writes 0 to idx 0..DEPTH-1, one word per cycle.
//    At the edge after idx DEPTH-1 is written, go to READY; mem_ready_o rises DEPTH+1 edges after reset release.
//  DMEM_INIT_CLEAR_EN undefined:
//    No clear logic. INIT -> READY at the first edge after reset release; RAM contents undefined.
// TESTING
//  1 Reset, init: release reset_n (macro on, DEPTH=16) -> mem_ready_o=0 for 16 edges, 1 after the 17th. Load of 0x2000 -> 0.
//  2 Stores and loads:
//    - word store 0xDEADBEEF @0x2004, then byte load @0x2006 -> 0x000000AD
//    - half store 0x1234 @0x2006, then word load @0x2004 -> 0x1234BEEF
//  3 Misalign:
//    - word load @0x2002 -> rd=0, mem_err_o=1, err_addr_o=0x2002
//    - then half @0x2001 -> err_addr_o stays 0x2002
//    - err_clr_i=1 -> flag 0
//  4 Range: store @0x1FFC and @BASE+DEPTH*4 -> no RAM change, err set; wr_cnt_o unchanged.
//  5 Counters, CNT_W=4: 20 valid loads -> rd_cnt_o=15 and holds.
//  6 Reset mid-operation: reset_n low during a store stream -> all outputs 0, INIT re-entered, RAM cleared again (macro on).

Source files
------------

// File: rtl/riscv_data_mem_responder.sv
// riscv_data_mem_responder: data-memory responder for the core's data_mem_* port.
// Word-organised RAM with byte/half/word lane steering, combinational loads and
// clock-edge stores, a sticky misalign/range error register, saturating access
// counters and a post-reset INIT -> READY sequencer.
// Optional feature macro: DMEM_INIT_CLEAR_EN (INIT zero-fills the RAM, one word per cycle).
module riscv_data_mem_responder #(
  parameter logic [31:0] BASE_ADDR = 32'h0000_2000,
  parameter int unsigned DEPTH     = 1024,
  parameter int unsigned CNT_W     = 16
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             data_mem_req_i,
  input  logic [31:0]      data_mem_addr_i,
  input  logic [1:0]       data_mem_byte_en_i,
  input  logic             data_mem_wr_i,
  input  logic [31:0]      data_mem_wr_data_i,
  output logic [31:0]      data_mem_rd_data_o,
  output logic             mem_ready_o,
  output logic             mem_err_o,
  output logic [31:0]      err_addr_o,
  input  logic             err_clr_i,
  output logic [CNT_W-1:0] rd_cnt_o,
  output logic [CNT_W-1:0] wr_cnt_o
);

  localparam int unsigned AW        = $clog2(DEPTH);
  localparam logic [31:0] MEM_BYTES = DEPTH * 4;

  typedef enum logic [0:0] {StInit, StReady} state_e;

  state_e            state_q;
  logic              ready_q;
  logic              err_q;
  logic [31:0]       err_addr_q;
  logic [CNT_W-1:0]  rd_cnt_q;
  logic [CNT_W-1:0]  wr_cnt_q;

  logic [31:0]       mem [DEPTH];

  logic [31:0]       off;
  logic [AW-1:0]     idx;
  logic [1:0]        lane;
  logic              in_range;
  logic              aligned;
  logic              access;
  logic              valid;
  logic              ld_valid;
  logic              st_valid;
  logic              err_set;
  logic [31:0]       rd_word;
  logic [31:0]       rd_shift;

  logic [3:0]        mem_be;
  logic [AW-1:0]     mem_widx;
  logic [31:0]       mem_wdata;

`ifdef DMEM_INIT_CLEAR_EN
  // Extra top bit marks "all words cleared" so READY is entered one edge later.
  logic [AW:0]       clr_idx_q;
`endif

  // Address decode, alignment check and access qualification.
  always_comb begin
    off      = data_mem_addr_i - BASE_ADDR;
    idx      = off[AW+1:2];
    lane     = off[1:0];
    in_range = (data_mem_addr_i >= BASE_ADDR) && (off < MEM_BYTES);
    case (data_mem_byte_en_i)
      2'b00:   aligned = 1'b1;
      2'b01:   aligned = ~lane[0];
      2'b10:   aligned = (lane == 2'b00);
      default: aligned = 1'b0;
    endcase
    access   = data_mem_req_i && ready_q;
    valid    = access && in_range && aligned;
    ld_valid = valid && !data_mem_wr_i;
    st_valid = valid && data_mem_wr_i;
    err_set  = access && !valid;
  end

  // Load path: right-align the addressed lanes, zero when no valid load.
  always_comb begin
    rd_word            = mem[idx];
    rd_shift           = rd_word >> {lane, 3'b000};
    data_mem_rd_data_o = '0;
    if (ld_valid) begin
      case (data_mem_byte_en_i)
        2'b00:   data_mem_rd_data_o = {24'b0, rd_shift[7:0]};
        2'b01:   data_mem_rd_data_o = {16'b0, rd_shift[15:0]};
        default: data_mem_rd_data_o = rd_word;
      endcase
    end
  end

  // Write port select: init clear or a steered store (never both at once).
  always_comb begin
    mem_be    = '0;
    mem_widx  = idx;
    mem_wdata = data_mem_wr_data_i;
    if (st_valid) begin
      case (data_mem_byte_en_i)
        2'b00: begin
          mem_be    = 4'b0001 << lane;
          mem_wdata = {4{data_mem_wr_data_i[7:0]}};
        end
        2'b01: begin
          mem_be    = 4'b0011 << lane;
          mem_wdata = {2{data_mem_wr_data_i[15:0]}};
        end
        default: mem_be = 4'b1111;
      endcase
    end
`ifdef DMEM_INIT_CLEAR_EN
    if (state_q == StInit && !clr_idx_q[AW]) begin
      mem_be    = 4'b1111;
      mem_widx  = clr_idx_q[AW-1:0];
      mem_wdata = '0;
    end
`endif
  end

  // RAM byte-lane writes; contents are not reset.
  always_ff @(posedge clk) begin
    for (int b = 0; b < 4; b++) begin
      if (mem_be[b]) mem[mem_widx][8*b +: 8] <= mem_wdata[8*b +: 8];
    end
  end

  // INIT/READY sequencer with registered ready output.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= StInit;
      ready_q   <= 1'b0;
`ifdef DMEM_INIT_CLEAR_EN
      clr_idx_q <= '0;
`endif
    end else begin
      case (state_q)
        StInit: begin
`ifdef DMEM_INIT_CLEAR_EN
          if (clr_idx_q[AW]) begin
            state_q <= StReady;
            ready_q <= 1'b1;
          end else begin
            clr_idx_q <= clr_idx_q + 1'b1;
          end
`else
          state_q <= StReady;
          ready_q <= 1'b1;
`endif
        end
        default: begin
          state_q <= StReady;
          ready_q <= 1'b1;
        end
      endcase
    end
  end

  // Sticky error flag; clear wins over a coincident new error.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      err_q      <= 1'b0;
      err_addr_q <= '0;
    end else if (err_clr_i) begin
      err_q      <= 1'b0;
      err_addr_q <= '0;
    end else if (err_set) begin
      err_q <= 1'b1;
      if (!err_q) err_addr_q <= data_mem_addr_i;
    end
  end

  // Saturating serviced-access counters.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rd_cnt_q <= '0;
      wr_cnt_q <= '0;
    end else begin
      if (ld_valid && (rd_cnt_q != '1)) rd_cnt_q <= rd_cnt_q + 1'b1;
      if (st_valid && (wr_cnt_q != '1)) wr_cnt_q <= wr_cnt_q + 1'b1;
    end
  end

  assign mem_ready_o = ready_q;
  assign mem_err_o   = err_q;
  assign err_addr_o  = err_addr_q;
  assign rd_cnt_o    = rd_cnt_q;
  assign wr_cnt_o    = wr_cnt_q;

endmodule
